uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
- Parametrised UART receiver; next generation of the fixed 8N1 receiver.
- Consumes the oversample enable from the baud-rate generator (os_tick).
- Supports configurable data width, oversampling factor, runtime parity mode and a valid/ready output handshake.
- Reports parity, framing and overrun errors.
- Sits between the rx pin and the host/FIFO logic.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9), LSB first.
- OVERSAMPLE, 8, os_tick pulses per bit period (even, 4..16).
- SYNC_STAGES, 2, input synchroniser depth (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- os_tick  in  1  one-clk pulse at OVERSAMPLE x baud rate.
- rx  in  1  serial line, idle high, asynchronous to clk.
- par_mode  in  2  00 none, 01 odd, 10 even, 11 none.
- rx_data  out  DATA_BITS  received word.
- rx_valid  out  1  rx_data/error flags valid.
- rx_ready  in  1  consumer accepts word when rx_valid && rx_ready.
- parity_err  out  1  parity mismatch for the held word.
- frame_err  out  1  stop bit sampled low for the held word.
- overrun  out  1  sticky: frame lost because the holding register was full.
- err_clr  in  1  one-clk pulse clears overrun.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; synchroniser flops preset to 1 (line idle); counters 0.
- rx passes through SYNC_STAGES flops; the FSM sees only rx_s.
- Tick counter tcnt ($clog2(OVERSAMPLE) bits) and bit counter bcnt advance only on os_tick.
- IDLE: on os_tick with rx_s==0, go to START with tcnt=0. par_mode is latched here and held for the frame.
- START: on each os_tick tcnt++. At tcnt==OVERSAMPLE/2-1 (mid-bit):
  - rx_s==0: go to DATA, tcnt=0, bcnt=0.
  - rx_s==1: glitch; return to IDLE with no flags.
- DATA: sample on os_tick when tcnt==OVERSAMPLE-1 (one bit period after the start mid-point). Shift the bit in LSB-first and bcnt++. After DATA_BITS samples go to PARITY if the latched mode is 01/10, else to STOP.
- PARITY: sample at the same point. Even mode: error if XOR(data,bit)!=0. Odd mode: error if XOR(data,bit)!=1.
- STOP: sample at the same point. frame_err_n = ~rx_s. Go to IDLE on the same os_tick. No wait for the full stop bit, so back-to-back frames work.
- Completion: on the clk after the stop sample, the holding register loads rx_data, parity_err and frame_err, and rx_valid=1. Latency is 1 clk from the stop-sample os_tick.
- Handshake:
  - rx_valid stays high and rx_data/flags stay stable until rx_valid&&rx_ready.
  - On acceptance, rx_valid drops the next clk unless a new completion occurs in the same cycle.
- Overrun:
  - Completion while rx_valid && !rx_ready: the new frame is discarded, the held word is kept, and overrun is set.
  - Completion in the same cycle as acceptance: the new word loads, rx_valid stays 1, no overrun.
- err_clr clears overrun. If err_clr and a new overrun occur in the same cycle, the set wins.
- Break (all zeros, stop low): delivered as data 0 with frame_err=1. The FSM then waits in IDLE for rx_s==1 before re-arming start detection.
- os_tick gaps: the FSM holds state; nothing advances without os_tick.
- rst mid-frame: immediate abort to the reset values; the partial word is never delivered.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit is the 2-of-3 majority of rx_s at tcnt==mid-1, mid and mid+1, measured from the bit centre. This applies to the start confirm, data, parity and stop samples; the start confirm uses the majority too. Sample latency is unchanged; the decision is taken at the mid+1 tick.
- Undefined: single sample at mid-bit as above.

Test Plan:
- OVERSAMPLE=8, os_tick every 4th clk, par_mode=00; send 0xA5 8N1 -> rx_valid 1 clk after the stop sample, rx_data=0xA5, all error flags 0.
- par_mode=10; send 0x3C with parity bit 1 -> parity_err=1, rx_data=0x3C. Repeat with parity bit 0 -> parity_err=0.
- Send 0x55 with stop bit 0 -> frame_err=1. Line held low 3 frame times -> one break word (0x00, frame_err=1), then no further words until rx returns high.
- rx_ready=0; send 0x11 then 0x22 -> rx_data stays 0x11, overrun=1. Then pulse rx_ready and err_clr -> overrun=0, rx_valid=0.
- Start glitch of 2 os_ticks low -> FSM returns to IDLE, busy drops, rx_valid stays 0.
- Assert rst mid-DATA of 0xFF -> all outputs 0 immediately. Next frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver with parity, error flags and valid/ready output
// Optional UART_RX_MAJORITY_EN: each bit decided by a 2-of-3 vote around its centre.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 os_tick,
    input  logic                 rx,
    input  logic [1:0]           par_mode,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 err_clr,
    output logic                 busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] T_START = TW'(OVERSAMPLE / 2);
`else
    localparam logic [TW-1:0] T_START = TW'(OVERSAMPLE / 2 - 1);
`endif
    localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   bit_s;
    state_t                 state;
    logic [TW-1:0]          tcnt;
    logic [BW-1:0]          bcnt;
    logic [DATA_BITS-1:0]   shreg;
    logic [1:0]             mode;
    logic                   perr_q;
    logic                   armed;
    logic                   done;
    logic [DATA_BITS-1:0]   done_data;
    logic                   done_perr;
    logic                   done_ferr;
    logic                   par_xor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
    assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    // Two previous tick samples; the vote completes with the current one at centre+1.
    logic [1:0] hist;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          hist <= 2'b11;
        else if (os_tick) hist <= {hist[0], rx_s};
    end
    assign bit_s = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign bit_s = rx_s;
`endif

    assign par_xor = (^shreg) ^ bit_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            tcnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            mode      <= 2'b00;
            perr_q    <= 1'b0;
            armed     <= 1'b1;
            done      <= 1'b0;
            done_data <= '0;
            done_perr <= 1'b0;
            done_ferr <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // After a low stop bit the line must go high before a new start is accepted.
                    if (!armed) begin
                        armed <= rx_s;
                    end else if (os_tick && !rx_s) begin
                        state  <= S_START;
                        busy   <= 1'b1;
                        tcnt   <= '0;
                        mode   <= par_mode;
                        perr_q <= 1'b0;
                    end
                end
                S_START: if (os_tick) begin
                    if (tcnt == T_START) begin
                        tcnt <= '0;
                        bcnt <= '0;
                        if (bit_s) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_DATA: if (os_tick) begin
                    if (tcnt == T_LAST) begin
                        tcnt  <= '0;
                        shreg <= {bit_s, shreg[DATA_BITS-1:1]};
                        if (bcnt == B_LAST)
                            state <= (mode == 2'b01 || mode == 2'b10) ? S_PARITY : S_STOP;
                        else
                            bcnt <= bcnt + 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_PARITY: if (os_tick) begin
                    if (tcnt == T_LAST) begin
                        tcnt   <= '0;
                        perr_q <= (mode == 2'b10) ? par_xor : ~par_xor;
                        state  <= S_STOP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_STOP: if (os_tick) begin
                    if (tcnt == T_LAST) begin
                        tcnt      <= '0;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        armed     <= bit_s;
                        done      <= 1'b1;
                        done_data <= shreg;
                        done_perr <= perr_q;
                        done_ferr <= ~bit_s;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= done_data;
                    parity_err <= done_perr;
                    frame_err  <= done_ferr;
                    rx_valid   <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            // A new overrun takes priority over a simultaneous clear.
            if (done && rx_valid && !rx_ready) overrun <= 1'b1;
            else if (err_clr)                  overrun <= 1'b0;
        end
    end
endmodule
